// File: rtl/uart_bus_arbiter_if.sv
// Bus bundle for the two-master UART arbiter.
// The master modport is the arbiter's view (bus master toward the UART); slave is the surrounding system's view.
interface uart_bus_arbiter_if;
  logic        m0_read;
  logic        m0_write;
  logic [31:0] m0_address;
  logic [31:0] m0_write_data;
  logic        m0_response;
  logic [31:0] m0_read_data;

  logic        m1_read;
  logic        m1_write;
  logic [31:0] m1_address;
  logic [31:0] m1_write_data;
  logic        m1_response;
  logic [31:0] m1_read_data;

  logic        s_read;
  logic        s_write;
  logic [31:0] s_address;
  logic [31:0] s_write_data;
  logic        s_response;
  logic [31:0] s_read_data;

  logic        bus_error;

  modport master (
    input  m0_read, m0_write, m0_address, m0_write_data,
    input  m1_read, m1_write, m1_address, m1_write_data,
    input  s_response, s_read_data,
    output m0_response, m0_read_data, m1_response, m1_read_data,
    output s_read, s_write, s_address, s_write_data, bus_error
  );

  modport slave (
    output m0_read, m0_write, m0_address, m0_write_data,
    output m1_read, m1_write, m1_address, m1_write_data,
    output s_response, s_read_data,
    input  m0_response, m0_read_data, m1_response, m1_read_data,
    input  s_read, s_write, s_address, s_write_data, bus_error
  );
endinterface

// File: rtl/uart_bus_arbiter.sv
// Round-robin two-master arbiter in front of the UART MMIO port.
// Optional slave-response watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_bus_arbiter #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERROR_DATA     = 32'hFFFFFFFF
) (
  input logic                clk,
  input logic                reset,
  uart_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state_reg;
  logic        grant_reg;
  logic        last_grant_reg;
  logic        req0;
  logic        req1;
  logic        pick;
  logic        timeout_hit;
  logic [31:0] rsp_data;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;
  // On a tie the master that was not served last wins.
  assign pick = (req0 & req1) ? ~last_grant_reg : req1;
  assign rsp_data = bus.s_response ? bus.s_read_data : ERROR_DATA;

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] timer_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_reg <= '0;
    end else if (state_reg == ISSUE || state_reg == WAIT) begin
      timer_reg <= timer_reg + 16'd1;
    end else begin
      timer_reg <= '0;
    end
  end

  // A real response on the same edge takes precedence over the abort.
  assign timeout_hit = (state_reg == WAIT) && !bus.s_response && (timer_reg == TIMEOUT_LAST);
`else
  logic unused_cfg;
  assign unused_cfg  = TIMEOUT_CYCLES[0];
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      grant_reg        <= 1'b0;
      last_grant_reg   <= 1'b1;
      bus.s_read       <= 1'b0;
      bus.s_write      <= 1'b0;
      bus.s_address    <= '0;
      bus.s_write_data <= '0;
      bus.m0_response  <= 1'b0;
      bus.m0_read_data <= '0;
      bus.m1_response  <= 1'b0;
      bus.m1_read_data <= '0;
      bus.bus_error    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req0 | req1) begin
            grant_reg        <= pick;
            // Write wins when a master raises both strobes.
            bus.s_write      <= pick ? bus.m1_write : bus.m0_write;
            bus.s_read       <= pick ? (bus.m1_read & ~bus.m1_write)
                                     : (bus.m0_read & ~bus.m0_write);
            bus.s_address    <= pick ? bus.m1_address : bus.m0_address;
            bus.s_write_data <= pick ? bus.m1_write_data : bus.m0_write_data;
            state_reg        <= ISSUE;
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (bus.s_response || timeout_hit) begin
            bus.s_read     <= 1'b0;
            bus.s_write    <= 1'b0;
            if (grant_reg) begin
              bus.m1_read_data <= rsp_data;
              bus.m1_response  <= 1'b1;
            end else begin
              bus.m0_read_data <= rsp_data;
              bus.m0_response  <= 1'b1;
            end
            bus.bus_error  <= timeout_hit;
            last_grant_reg <= grant_reg;
            state_reg      <= DONE;
          end
        end
        DONE: begin
          bus.m0_response <= 1'b0;
          bus.m1_response <= 1'b0;
          bus.bus_error   <= 1'b0;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Scoreboard bench for uart_bus_arbiter: directed transactions, a small UART responder,
// and independent monitors for slave-side issue and master-side responses.
module tb_uart_bus_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif
  localparam int UART_LAT = 2;

  typedef struct {
    bit          mid;
    bit          exp_sr;
    bit          exp_sw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
  } txn_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   uart_mute = 1'b0;
  bit   stray = 1'b0;
  bit   sr_seen = 1'b0;
  int   total = 0;
  int   bad = 0;
  txn_t exp_iss[$];
  txn_t exp_rsp[$];

  uart_bus_arbiter_if bus ();

  uart_bus_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push(bit mid, bit sr, bit sw, logic [31:0] a, logic [31:0] d,
                      logic [31:0] rd, bit err);
    txn_t t;
    t.mid = mid; t.exp_sr = sr; t.exp_sw = sw; t.addr = a; t.wdata = d;
    t.rdata = rd; t.err = err;
    exp_iss.push_back(t);
    exp_rsp.push_back(t);
  endtask

  task automatic drive(bit mid, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    if (mid) begin
      bus.m1_read = rd; bus.m1_write = wr; bus.m1_address = a; bus.m1_write_data = d;
    end else begin
      bus.m0_read = rd; bus.m0_write = wr; bus.m0_address = a; bus.m0_write_data = d;
    end
  endtask

  // Waits (bounded) for the master's response, then drops its request during the pulse.
  task automatic wait_rsp(bit mid, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mid ? bus.m1_response : bus.m0_response) && n < 100);
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL rsp_timeout: m%0d got no response after %0d cycles, required one", mid, n);
    end
    drive(mid, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic run_txn(bit mid, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    int n;
    @(negedge clk);
    drive(mid, rd, wr, a, d);
    wait_rsp(mid, n);
  endtask

  function automatic logic [31:0] uart_rd(logic [31:0] a);
    if (a == 32'h200B) return 32'h1;
    return a ^ 32'h0F0F0000;
  endfunction

  // UART responder: answers UART_LAT+1 cycles after it sees a request; returns 0 on writes.
  initial begin
    int lat = 0;
    bus.s_response  = 1'b0;
    bus.s_read_data = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.s_response) begin
        bus.s_response = 1'b0;
      end else if (stray) begin
        bus.s_response = 1'b1;
        stray = 1'b0;
      end else if (!uart_mute && (bus.s_read || bus.s_write)) begin
        if (lat == UART_LAT) begin
          bus.s_response  = 1'b1;
          bus.s_read_data = bus.s_write ? 32'h0 : uart_rd(bus.s_address);
          lat = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    sr_seen = bus.s_response;
  end

  // Issue monitor: checks the latched slave request at the start of each access.
  initial begin
    bit prev_act = 1'b0;
    bit act;
    txn_t e;
    forever begin
      @(negedge clk);
      act = bus.s_read | bus.s_write;
      if (act && !prev_act && !reset) begin
        if (exp_iss.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_issue: got addr %h, required no access", bus.s_address);
        end else begin
          e = exp_iss.pop_front();
          check("iss_s_write", {31'b0, bus.s_write}, {31'b0, e.exp_sw});
          check("iss_s_read", {31'b0, bus.s_read}, {31'b0, e.exp_sr});
          check("iss_s_address", bus.s_address, e.addr);
          check("iss_s_write_data", bus.s_write_data, e.wdata);
        end
      end
      prev_act = act;
    end
  end

  // Response monitor: right master, data, hold of the other master, error flag, latency.
  initial begin
    logic [31:0] last0 = 32'h0;
    logic [31:0] last1 = 32'h0;
    txn_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        last0 = 32'h0;
        last1 = 32'h0;
      end else if (bus.m0_response || bus.m1_response) begin
        if (exp_rsp.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_rsp: got m0=%b m1=%b, required none",
                   bus.m0_response, bus.m1_response);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_master", {30'b0, bus.m1_response, bus.m0_response},
                e.mid ? 32'd2 : 32'd1);
          check("rsp_read_data", e.mid ? bus.m1_read_data : bus.m0_read_data, e.rdata);
          check("rsp_other_hold", e.mid ? bus.m0_read_data : bus.m1_read_data,
                e.mid ? last0 : last1);
          check("rsp_bus_error", {31'b0, bus.bus_error}, {31'b0, e.err});
          check("rsp_after_s_response", {31'b0, sr_seen}, {31'b0, !e.err});
          if (e.mid) last1 = e.rdata; else last0 = e.rdata;
        end
      end else if (bus.bus_error) begin
        total++; bad++;
        $display("FAIL stray_bus_error: got 1 without response, required 0");
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] m0_rd_tab [4];
    m0_rd_tab[0] = 32'h0F0F3000; m0_rd_tab[1] = 32'h0F0F3004;
    m0_rd_tab[2] = 32'h0F0F3008; m0_rd_tab[3] = 32'h0F0F300C;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {27'b0, bus.s_read, bus.s_write, bus.m0_response,
                            bus.m1_response, bus.bus_error}, 32'h0);
    check("reset_s_address", bus.s_address | bus.s_write_data, 32'h0);
    check("reset_read_data", bus.m0_read_data | bus.m1_read_data, 32'h0);
    reset = 1'b0;

    // m0 write, slave request visible one cycle after the request edge
    push(1'b0, 1'b0, 1'b1, 32'h2007, 32'h41, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h2007, 32'h41);
    @(negedge clk);
    check("t1_s_write_next_cycle", {31'b0, bus.s_write}, 32'h1);
    check("t1_s_address_next_cycle", bus.s_address, 32'h2007);
    wait_rsp(1'b0, n);

    // m1 read
    push(1'b1, 1'b1, 1'b0, 32'h200B, 32'h0, 32'h1, 1'b0);
    run_txn(1'b1, 1'b1, 1'b0, 32'h200B, 32'h0);

    // Both masters streaming from reset: m0, m1, m0, m1, ...
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(1'b0, 1'b1, 1'b0, 32'h3000 + 32'(i * 4), 32'h0, m0_rd_tab[i], 1'b0);
      push(1'b1, 1'b0, 1'b1, 32'h4000 + 32'(i * 4), 32'hD0 + 32'(i), 32'h0, 1'b0);
    end
    fork
      for (int i = 0; i < 4; i++) run_txn(1'b0, 1'b1, 1'b0, 32'h3000 + 32'(i * 4), 32'h0);
      for (int j = 0; j < 4; j++) run_txn(1'b1, 1'b0, 1'b1, 32'h4000 + 32'(j * 4), 32'hD0 + 32'(j));
    join

    // Stray s_response while idle must be ignored
    stray = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_idle_after_stray", {28'b0, bus.s_read, bus.s_write, bus.m0_response,
                                  bus.m1_response}, 32'h0);

    // Read and write together: write wins
    push(1'b0, 1'b0, 1'b1, 32'h2010, 32'h55, 32'h0, 1'b0);
    run_txn(1'b0, 1'b1, 1'b1, 32'h2010, 32'h55);

    // Reset while waiting on the UART
    uart_mute = 1'b1;
    push(1'b1, 1'b1, 1'b0, 32'h2020, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h2020, 32'h0);
    repeat (4) @(negedge clk);
    check("t5_waiting_s_read", {31'b0, bus.s_read}, 32'h1);
    reset = 1'b1;
    #1;
    check("t5_reset_immediate", {27'b0, bus.s_read, bus.s_write, bus.m0_response,
                                 bus.m1_response, bus.bus_error}, 32'h0);
    exp_rsp.delete();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    uart_mute = 1'b0;
    push(1'b0, 1'b0, 1'b1, 32'h2040, 32'h77, 32'h0, 1'b0);
    run_txn(1'b0, 1'b0, 1'b1, 32'h2040, 32'h77);

`ifdef UART_ARB_TIMEOUT_EN
    // Silent UART: watchdog aborts with ERROR_DATA and bus_error
    uart_mute = 1'b1;
    push(1'b0, 1'b1, 1'b0, 32'h2030, 32'h0, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'h2030, 32'h0);
    wait_rsp(1'b0, n);
    check("t6_abort_latency", 32'(n), 32'd17);
    uart_mute = 1'b0;
`endif

    repeat (10) @(negedge clk);
    check("queues_drained", 32'(exp_iss.size() + exp_rsp.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
